qspi_sram_responder: RTL and testbench

Synthesizable responder for the serial-SRAM bus that the SoC's ram/rom/vram controllers drive: cs_n, sck, and four SIO lines. It decodes SPI and SQI (quad) command frames in the style of the 23LC1024 and serves byte reads and writes from a synchronous byte-wide memory port. It sits on-chip or in an FPGA test harness in place of an external SRAM. All bus inputs are oversampled in the system clock domain; there is no sck clock domain.

---
 rtl/qspi_sram_responder_pkg.sv | 29 ++
 rtl/qspi_sram_responder_in_sync.sv | 53 +++++
 rtl/qspi_sram_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_qspi_sram_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
//  qspi_sram_defs
//  Shared definitions for the serial-SRAM responder: bus opcodes, the FSM
//  state encoding and the SQI read dummy-cycle count.
//  Revision: 1.0 - initial release
// ============================================================================
package qspi_sram_defs;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_EQIO  = 8'h38;
    localparam logic [7:0] CMD_RSTIO = 8'hFF;

    // Dummy sck cycles between address and data on an SQI read
    localparam logic [1:0] DUMMY_CYCLES_SQI = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/qspi_sram_responder_in_sync.sv
`default_nettype none
// ============================================================================
//  qspi_in_sync
//  Brings the serial-SRAM bus into the system clock domain.
//  cs_n and sio_i pass through two flops; sck passes through two flops plus
//  one history flop used for rise/fall detection, so the edge pulses line up
//  with the synchronized sio value captured on the same sck edge.
//  Ports:
//    clk, reset_n        system clock, async active-low reset
//    cs_n, sck, sio_i    raw bus inputs
//    cs_n_sync           synchronized chip select
//    sck_rise, sck_fall  one-clk pulses on synchronized sck edges
//    sio_sync            synchronized SIO inputs
//  Revision: 1.0 - initial release
// ============================================================================
module qspi_in_sync (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs_n,
    input  logic       sck,
    input  logic [3:0] sio_i,
    output logic       cs_n_sync,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic [3:0] sio_sync
);

    logic [1:0] r_cs_pipe;
    logic [2:0] r_sck_pipe;
    logic [3:0] r_sio_meta;
    logic [3:0] r_sio_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_pipe  <= 2'b11;
            r_sck_pipe <= 3'b000;
            r_sio_meta <= 4'h0;
            r_sio_sync <= 4'h0;
        end else begin
            r_cs_pipe  <= {r_cs_pipe[0], cs_n};
            r_sck_pipe <= {r_sck_pipe[1:0], sck};
            r_sio_meta <= sio_i;
            r_sio_sync <= r_sio_meta;
        end
    end

    assign cs_n_sync = r_cs_pipe[1];
    assign sck_rise  =  r_sck_pipe[1] & ~r_sck_pipe[2];
    assign sck_fall  = ~r_sck_pipe[1] &  r_sck_pipe[2];
    assign sio_sync  = r_sio_sync;

endmodule
`default_nettype wire

// File: rtl/qspi_sram_responder.sv
`default_nettype none
// ============================================================================
//  qspi_sram_responder
//  23LC1024-style SPI/SQI serial-SRAM responder serving a byte-wide
//  synchronous memory port. Bus inputs are oversampled in clk.
//  Ports:
//    clk, reset_n              system clock, async active-low reset
//    cs_n, sck, sio_i          serial bus inputs
//    sio_o, sio_oe             serial bus outputs and per-line enables
//    mem_addr, mem_re          read request (mem_rdata valid next clk)
//    mem_rdata                 read data
//    mem_we, mem_wdata         one-cycle write strobe and data
//  Revision: 1.0 - initial release
// ============================================================================
module qspi_sram_responder
    import qspi_sram_defs::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs_n,
    input  logic              sck,
    input  logic [3:0]        sio_i,
    output logic [3:0]        sio_o,
    output logic [3:0]        sio_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata
);

    logic       w_cs_n;
    logic       w_rise;
    logic       w_fall;
    logic [3:0] w_sio;

    qspi_in_sync u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .cs_n      (cs_n),
        .sck       (sck),
        .sio_i     (sio_i),
        .cs_n_sync (w_cs_n),
        .sck_rise  (w_rise),
        .sck_fall  (w_fall),
        .sio_sync  (w_sio)
    );

    state_t            r_state;
    logic              r_quad;
    logic              r_eqio_pend;
    logic              r_rstio_pend;
    logic              r_is_read;
    logic [4:0]        r_bitcnt;
    logic [1:0]        r_dummy_cnt;
    logic [23:0]       r_sh_in;
    logic [7:0]        r_sh_out;
    logic [7:0]        r_rd_buf;
    logic              r_re_d1;
    logic [3:0]        r_sio_o;
    logic [3:0]        r_sio_oe;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [7:0]        r_mem_wdata;

    logic [4:0]        w_step;
    logic [4:0]        w_cnt_next;
    logic [23:0]       w_sh_next;
    logic [7:0]        w_rd_byte;
    logic [7:0]        w_out_src;
    logic              w_unused;

    assign w_step     = r_quad ? 5'd4 : 5'd1;
    assign w_cnt_next = r_bitcnt + w_step;
    assign w_sh_next  = r_quad ? {r_sh_in[19:0], w_sio} : {r_sh_in[22:0], w_sio[0]};
    // The first output edge can arrive in the same clk the read data
    // lands, so bypass the holding register in that cycle.
    assign w_rd_byte  = r_re_d1 ? mem_rdata : r_rd_buf;
    assign w_out_src  = (r_bitcnt == 5'd0) ? w_rd_byte : r_sh_out;
    assign w_unused   = r_sh_in[23];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_quad       <= 1'b0;
            r_eqio_pend  <= 1'b0;
            r_rstio_pend <= 1'b0;
            r_is_read    <= 1'b0;
            r_bitcnt     <= 5'd0;
            r_dummy_cnt  <= 2'd0;
            r_sh_in      <= 24'h0;
            r_sh_out     <= 8'h0;
            r_rd_buf     <= 8'h0;
            r_re_d1      <= 1'b0;
            r_sio_o      <= 4'h0;
            r_sio_oe     <= 4'h0;
            r_mem_addr   <= '0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= 8'h0;
        end else begin
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            r_re_d1  <= r_mem_re;
            if (r_re_d1) begin
                r_rd_buf <= mem_rdata;
            end
            // Post-increment after each write strobe; wraps modulo 2^ADDR_W
            if (r_mem_we) begin
                r_mem_addr <= r_mem_addr + ADDR_W'(1);
            end

            // cs_n high dominates any sck edge seen in the same clk
            if (w_cs_n) begin
                r_state      <= ST_IDLE;
                r_bitcnt     <= 5'd0;
                r_sio_o      <= 4'h0;
                r_sio_oe     <= 4'h0;
                r_eqio_pend  <= 1'b0;
                r_rstio_pend <= 1'b0;
                if (r_eqio_pend) begin
                    r_quad <= 1'b1;
                end
                if (r_rstio_pend) begin
                    r_quad <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state  <= ST_CMD;
                        r_bitcnt <= 5'd0;
                        r_sh_in  <= 24'h0;
                    end
                    ST_CMD: if (w_rise) begin
                        r_sh_in  <= w_sh_next;
                        r_bitcnt <= w_cnt_next;
                        if (w_cnt_next == 5'd8) begin
                            r_bitcnt <= 5'd0;
                            r_state  <= ST_IGNORE;
                            case (w_sh_next[7:0])
                                CMD_READ: begin
                                    r_is_read <= 1'b1;
                                    r_state   <= ST_ADDR;
                                end
                                CMD_WRITE: begin
                                    r_is_read <= 1'b0;
                                    r_state   <= ST_ADDR;
                                end
                                CMD_EQIO:  r_eqio_pend  <= ~r_quad;
                                CMD_RSTIO: r_rstio_pend <= 1'b1;
                                default:   r_state      <= ST_IGNORE;
                            endcase
                        end
                    end
                    ST_ADDR: if (w_rise) begin
                        r_sh_in  <= w_sh_next;
                        r_bitcnt <= w_cnt_next;
                        if (w_cnt_next == 5'd24) begin
                            r_bitcnt   <= 5'd0;
                            r_mem_addr <= w_sh_next[ADDR_W-1:0];
                            if (r_is_read) begin
                                r_mem_re    <= 1'b1;
                                r_dummy_cnt <= 2'd0;
                                r_state     <= r_quad ? ST_DUMMY : ST_RDATA;
                            end else begin
                                r_state <= ST_WDATA;
                            end
                        end
                    end
                    ST_DUMMY: if (w_rise) begin
                        r_dummy_cnt <= r_dummy_cnt + 2'd1;
                        if ((r_dummy_cnt + 2'd1) == DUMMY_CYCLES_SQI) begin
                            r_state <= ST_RDATA;
                        end
                    end
                    ST_RDATA: if (w_fall) begin
                        r_sio_oe <= r_quad ? 4'hF : 4'h2;
                        if (r_quad) begin
                            r_sio_o  <= w_out_src[7:4];
                            r_sh_out <= {w_out_src[3:0], 4'h0};
                        end else begin
                            r_sio_o  <= {2'b00, w_out_src[7], 1'b0};
                            r_sh_out <= {w_out_src[6:0], 1'b0};
                        end
                        // Last bit of the byte is on the wire: prefetch the next
                        if (w_cnt_next == 5'd8) begin
                            r_bitcnt   <= 5'd0;
                            r_mem_re   <= 1'b1;
                            r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        end else begin
                            r_bitcnt <= w_cnt_next;
                        end
                    end
                    ST_WDATA: if (w_rise) begin
                        r_sh_in  <= w_sh_next;
                        r_bitcnt <= w_cnt_next;
                        if (w_cnt_next == 5'd8) begin
                            r_bitcnt    <= 5'd0;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= w_sh_next[7:0];
                        end
                    end
                    ST_IGNORE: r_state <= ST_IGNORE;
                    default:   r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign sio_o     = r_sio_o;
    assign sio_oe    = r_sio_oe;
    assign mem_addr  = r_mem_addr;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_qspi_sram_responder.sv
`default_nettype none
// ============================================================================
//  tb_qspi_sram_responder
//  Bus-master bench for qspi_sram_responder: a table of SPI/SQI frames with
//  expected memory writes and read data, plus hand-written aborted-byte and
//  reset-mid-read sequences. Backing memory is a simple synchronous array.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_qspi_sram_responder;

    localparam int ADDR_W = 17;
    localparam int H      = 6;   // sck half period in clk cycles

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cs_n;
    logic              sck;
    logic [3:0]        sio_i;
    logic [3:0]        sio_o;
    logic [3:0]        sio_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [7:0]        mem_rdata = 8'h00;
    logic              mem_we;
    logic [7:0]        mem_wdata;

    qspi_sram_responder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cs_n      (cs_n),
        .sck       (sck),
        .sio_i     (sio_i),
        .sio_o     (sio_o),
        .sio_oe    (sio_oe),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    logic [ADDR_W+7:0] wq[$];   // expected {addr, data} of each mem_we
    logic [7:0]        rq[$];   // expected read bytes
    logic [ADDR_W+7:0] exp_w;

    typedef struct {
        logic        quad;
        logic [7:0]  op;
        logic [23:0] addr;
        int          n;
        logic [7:0]  d0;
        logic [7:0]  d1;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && mem_we) begin
            we_cnt++;
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mem_we actual=%0h expected=none", {mem_addr, mem_wdata});
            end else begin
                exp_w = wq.pop_front();
                chk("mem_write", 64'({mem_addr, mem_wdata}), 64'(exp_w));
            end
        end
    end

    task automatic clk_cycle(input logic [3:0] v);
        sio_i = v;
        repeat (H) @(negedge clk);
        sck = 1'b1;
        repeat (H) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_byte(input logic q, input logic [7:0] b);
        if (q) begin
            clk_cycle(b[7:4]);
            clk_cycle(b[3:0]);
        end else begin
            for (int i = 7; i >= 0; i--) clk_cycle({3'b000, b[i]});
        end
    endtask

    task automatic recv_byte(input logic q, output logic [7:0] b);
        logic [3:0] exp_oe;
        exp_oe = q ? 4'hF : 4'h2;
        b = 8'h00;
        for (int k = 0; k < (q ? 2 : 8); k++) begin
            repeat (H) @(negedge clk);
            if (k == 0) chk("read_oe", 64'(sio_oe), 64'(exp_oe));
            b = q ? {b[3:0], sio_o} : {b[6:0], sio_o[1]};
            sck = 1'b1;
            repeat (H) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic begin_frame(input logic q, input logic [7:0] op, input logic [23:0] addr);
        cs_n = 1'b0;
        repeat (H) @(negedge clk);
        send_byte(q, op);
        if (op == 8'h02 || op == 8'h03) begin
            send_byte(q, addr[23:16]);
            send_byte(q, addr[15:8]);
            send_byte(q, addr[7:0]);
        end
    endtask

    task automatic end_frame();
        repeat (H) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * H) @(negedge clk);
        chk("frame_end_oe", 64'(sio_oe), 64'h0);
        chk("writes_drained", 64'(wq.size()), 64'h0);
    endtask

    task automatic run_frame(input vec_t v);
        logic [7:0] got;
        logic [7:0] exp;
        if (v.op == 8'h02) begin
            wq.push_back({ADDR_W'(v.addr), v.d0});
            if (v.n > 1) wq.push_back({ADDR_W'(v.addr + 24'd1), v.d1});
        end
        if (v.op == 8'h03) begin
            rq.push_back(v.d0);
            if (v.n > 1) rq.push_back(v.d1);
        end
        begin_frame(v.quad, v.op, v.addr);
        if (v.op == 8'h02) begin
            send_byte(v.quad, v.d0);
            if (v.n > 1) send_byte(v.quad, v.d1);
            chk("write_oe", 64'(sio_oe), 64'h0);
        end
        if (v.op == 8'h03) begin
            if (v.quad) begin
                chk("pre_dummy_oe", 64'(sio_oe), 64'h0);
                repeat (2) clk_cycle(4'h0);
            end
            for (int i = 0; i < v.n; i++) begin
                recv_byte(v.quad, got);
                exp = rq.pop_front();
                chk("read_data", 64'(got), 64'(exp));
            end
        end
        end_frame();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        logic [7:0] exp;
        int         we_before;

        tbl[0] = '{1'b0, 8'h02, 24'h000010, 2, 8'hA5, 8'h3C};
        tbl[1] = '{1'b0, 8'h03, 24'h000010, 2, 8'hA5, 8'h3C};
        tbl[2] = '{1'b0, 8'h5A, 24'h000000, 0, 8'h00, 8'h00};
        tbl[3] = '{1'b0, 8'h38, 24'h000000, 0, 8'h00, 8'h00};
        tbl[4] = '{1'b1, 8'h03, 24'h000010, 2, 8'hA5, 8'h3C};
        tbl[5] = '{1'b1, 8'h02, 24'h01FFFF, 2, 8'h11, 8'h22};
        tbl[6] = '{1'b1, 8'h03, 24'h01FFFF, 2, 8'h11, 8'h22};
        tbl[7] = '{1'b1, 8'hFF, 24'h000000, 0, 8'h00, 8'h00};
        tbl[8] = '{1'b0, 8'h03, 24'h01FFFF, 2, 8'h11, 8'h22};
        tbl[9] = '{1'b0, 8'h03, 24'hFE0010, 2, 8'hA5, 8'h3C};

        reset_n = 1'b0;
        cs_n    = 1'b1;
        sck     = 1'b0;
        sio_i   = 4'h0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({sio_o, sio_oe, mem_re, mem_we, mem_addr, mem_wdata}), 64'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 10; i++) run_frame(tbl[i]);

        // Aborted byte: cs_n rises after 4 data bits of a write
        we_before = we_cnt;
        begin_frame(1'b0, 8'h02, 24'h000020);
        for (int i = 0; i < 4; i++) clk_cycle(4'h1);
        end_frame();
        chk("abort_no_we", 64'(we_cnt), 64'(we_before));
        run_frame('{1'b0, 8'h03, 24'h000010, 2, 8'hA5, 8'h3C});

        // Reset in the middle of an SQI read
        run_frame('{1'b0, 8'h38, 24'h000000, 0, 8'h00, 8'h00});
        rq.push_back(8'hA5);
        begin_frame(1'b1, 8'h03, 24'h000010);
        repeat (2) clk_cycle(4'h0);
        recv_byte(1'b1, got);
        exp = rq.pop_front();
        chk("pre_reset_read", 64'(got), 64'(exp));
        reset_n = 1'b0;
        #1;
        chk("mid_read_reset", 64'({sio_o, sio_oe, mem_re, mem_we, mem_addr, mem_wdata}), 64'h0);
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        run_frame('{1'b0, 8'h03, 24'h000010, 2, 8'hA5, 8'h3C});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
